// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared datapath through fetch, decode and execute steps for
// lw, sw, R-type, I-type ALU, beq and jal, and traps on anything else.
// The state register and the state-decoded control fields are held in one
// registered block. Only the handshake-gated enables are combinational.
module mc_main_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  // Moore control fields decoded from a state. fetch and mem_write double as
  // markers for the enables that are qualified by mem_ready.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       branch;
    logic       pc_update;
    logic       fetch;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   pc_update;

  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.fetch      = 1'b1;
      end
      StDecode: begin
        // Precompute the branch target from OldPC + ImmExt.
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      StMemRead: begin
        c.adr_src = 1'b1;
      end
      StMemWb: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      StMemWrite: begin
        // Strobe held through every wait cycle; retire is gated by mem_ready.
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      StExecuteR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      StExecuteI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      StAluWb: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      StBeq: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
        c.retire    = 1'b1;
      end
      StJal: begin
        // Redirect PC to the precomputed target and form OldPC + 4 for ALUWB.
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      StTrap: begin
        c.illegal = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Next-state logic; unreachable encodings fall into TRAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StMemWb:    state_d = StFetch;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  // State register plus registered control fields for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      ctrl_q  <= decode_ctrl(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  // Output drive; reset_n gates the enables so nothing writes while held in reset.
  always_comb begin
    pc_update = ctrl_q.pc_update | (ctrl_q.fetch & mem_ready);
    PCWrite   = reset_n & (pc_update | (ctrl_q.branch & zero));
    IRWrite   = reset_n & ctrl_q.fetch & mem_ready;
    MemWrite  = reset_n & ctrl_q.mem_write;
    RegWrite  = reset_n & ctrl_q.reg_write;
    retire    = reset_n & (ctrl_q.retire | (ctrl_q.mem_write & mem_ready));
    AdrSrc    = ctrl_q.adr_src;
    ResultSrc = ctrl_q.result_src;
    ALUSrcA   = ctrl_q.alu_src_a;
    ALUSrcB   = ctrl_q.alu_src_b;
    ALUOp     = ctrl_q.alu_op;
    illegal   = ctrl_q.illegal;
    state     = state_q;
  end

  // Immediate format straight from the opcode, independent of state.
  always_comb begin
    case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

endmodule
